// File: rtl/adder_stim_gen.sv
// rtl/adder_stim_gen.sv - operand-pair stimulus generator for adder self-test
//
// Feeds an adder under test and its reference adder with {A,B} operand pairs.
// Two run modes:
//   exhaustive - walks every pair 0 .. 2^(2*WIDTH)-1 (B inner, A outer)
//   random     - emits num_vec pairs taken from a seeded 32-bit Galois LFSR
// Vectors leave through a valid/ready handshake so a downstream compare
// stage can stall the stream.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      one-cycle run request, honoured only in IDLE
//   mode       0 = exhaustive, 1 = random (latched on accepted start)
//   seed       LFSR seed, 0 is replaced by 1 (latched on accepted start)
//   num_vec    random-mode vector count (latched on accepted start)
//   a_out      operand A
//   b_out      operand B
//   vec_valid  a_out/b_out hold a valid vector
//   vec_ready  consumer accepts the current vector
//   busy       high in RUN and DONE
//   done       one-cycle pulse after the last transfer
//   vec_count  transfers in the current/last run

module adder_stim_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      seed,
  input  logic [31:0]      num_vec,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      vec_count
);

  localparam int CW = 2 * WIDTH;
  localparam logic [31:0]   LFSR_POLY = 32'h8020_0003;
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic           mode_q;
  logic [31:0]    num_q;
  logic [31:0]    lfsr;
  logic [CW-1:0]  cnt;
  logic [31:0]    count_q;

  logic           accept;
  logic           xfer;
  logic           last_xfer;
  logic [31:0]    seed_eff;

  // Right-shift Galois step; a non-zero state can never step to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    if (v[0]) begin
      return (v >> 1) ^ LFSR_POLY;
    end
    return v >> 1;
  endfunction

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  assign seed_eff = (seed == 32'd0) ? 32'd1 : seed;

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer      = (state == S_RUN) && vec_ready;
    last_xfer = 1'b0;

    if (mode_q) begin
      last_xfer = xfer && ((count_q + 32'd1) == num_q);
    end else begin
      last_xfer = xfer && (cnt == CNT_MAX);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (mode && (num_vec == 32'd0)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last_xfer) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // start arriving with the done pulse is deliberately dropped
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      num_q   <= 32'd0;
      lfsr    <= 32'd1;
      cnt     <= '0;
      count_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q  <= mode;
        num_q   <= num_vec;
        lfsr    <= seed_eff;
        cnt     <= '0;
        count_q <= 32'd0;
      end else if (xfer) begin
        // vec_count wraps to 0 on the final exhaustive transfer when
        // WIDTH=16; the exhaustive counter also wraps, but the FSM leaves
        // RUN on that same edge so the wrapped pair is never presented.
        count_q <= count_q + 32'd1;
        if (mode_q) begin
          lfsr <= lfsr_step(lfsr);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Outputs; operands read as zero whenever no vector is offered
  always_comb begin
    vec_valid = (state == S_RUN);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    vec_count = count_q;
    a_out     = '0;
    b_out     = '0;
    if (vec_valid) begin
      if (mode_q) begin
        a_out = lfsr[WIDTH-1:0];
        b_out = lfsr[CW-1:WIDTH];
      end else begin
        a_out = cnt[CW-1:WIDTH];
        b_out = cnt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_adder_stim_gen.sv
// tb/tb_adder_stim_gen.sv - directed self-checking bench for adder_stim_gen

module tb_adder_stim_gen;

  logic        clk;
  logic        reset;

  // WIDTH=2 instance (exhaustive tests)
  logic        start2;
  logic        mode2;
  logic [31:0] seed2;
  logic [31:0] num2;
  logic        ready2;
  logic [1:0]  a2;
  logic [1:0]  b2;
  logic        valid2;
  logic        busy2;
  logic        done2;
  logic [31:0] cnt2;

  // WIDTH=8 instance (random tests)
  logic        start8;
  logic        mode8;
  logic [31:0] seed8;
  logic [31:0] num8;
  logic        ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        valid8;
  logic        busy8;
  logic        done8;
  logic [31:0] cnt8;

  int n_checks;
  int n_pass;

  adder_stim_gen #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .mode      (mode2),
    .seed      (seed2),
    .num_vec   (num2),
    .a_out     (a2),
    .b_out     (b2),
    .vec_valid (valid2),
    .vec_ready (ready2),
    .busy      (busy2),
    .done      (done2),
    .vec_count (cnt2)
  );

  adder_stim_gen #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start8),
    .mode      (mode8),
    .seed      (seed8),
    .num_vec   (num8),
    .a_out     (a8),
    .b_out     (b8),
    .vec_valid (valid8),
    .vec_ready (ready8),
    .busy      (busy8),
    .done      (done8),
    .vec_count (cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] rnd_a [3];
  logic [7:0] rnd_b [3];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rnd_a[0] = 8'h01; rnd_a[1] = 8'h03; rnd_a[2] = 8'h02;
    rnd_b[0] = 8'h00; rnd_b[1] = 8'h00; rnd_b[2] = 8'h00;

    reset  = 1'b1;
    start2 = 1'b0; mode2 = 1'b0; seed2 = 32'd0; num2 = 32'd0; ready2 = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; seed8 = 32'd0; num8 = 32'd0; ready8 = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_a",     {30'd0, a2}, 32'd0);
    check("rst_b",     {30'd0, b2}, 32'd0);
    check("rst_valid", {31'd0, valid2}, 32'd0);
    check("rst_busy",  {31'd0, busy2}, 32'd0);
    check("rst_done",  {31'd0, done2}, 32'd0);
    check("rst_count", cnt2, 32'd0);
    check("rst_a8",    {24'd0, a8}, 32'd0);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    reset = 1'b0;

    // Exhaustive WIDTH=2, with a stray start (random, num=1) while busy
    @(negedge clk);
    start2 = 1'b1; mode2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("exh_a[%0d]", i), {30'd0, a2}, i / 4);
      check($sformatf("exh_b[%0d]", i), {30'd0, b2}, i % 4);
      check($sformatf("exh_valid[%0d]", i), {31'd0, valid2}, 32'd1);
      check($sformatf("exh_count[%0d]", i), cnt2, i);
      check($sformatf("exh_done[%0d]", i), {31'd0, done2}, 32'd0);
      if (i == 3) begin
        start2 = 1'b1; mode2 = 1'b1; num2 = 32'd1;
      end else begin
        start2 = 1'b0; mode2 = 1'b0; num2 = 32'd0;
      end
      @(negedge clk);
    end
    check("exh_done",      {31'd0, done2}, 32'd1);
    check("exh_done_busy", {31'd0, busy2}, 32'd1);
    check("exh_end_valid", {31'd0, valid2}, 32'd0);
    check("exh_end_count", cnt2, 32'd16);
    @(negedge clk);
    check("exh_post_done",  {31'd0, done2}, 32'd0);
    check("exh_post_busy",  {31'd0, busy2}, 32'd0);
    check("exh_post_count", cnt2, 32'd16);

    // Reset after 5 exhaustive transfers
    start2 = 1'b1; mode2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort_b[%0d]", i), {30'd0, b2}, i % 4);
      @(negedge clk);
    end
    check("abort_count_pre", cnt2, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_a",     {30'd0, a2}, 32'd0);
    check("abort_b",     {30'd0, b2}, 32'd0);
    check("abort_valid", {31'd0, valid2}, 32'd0);
    check("abort_busy",  {31'd0, busy2}, 32'd0);
    check("abort_done",  {31'd0, done2}, 32'd0);
    check("abort_count", cnt2, 32'd0);
    @(negedge clk);
    check("abort_done2", {31'd0, done2}, 32'd0);
    check("abort_busy2", {31'd0, busy2}, 32'd0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("restart_a0", {30'd0, a2}, 32'd0);
    check("restart_b0", {30'd0, b2}, 32'd0);
    @(negedge clk);
    check("restart_a1", {30'd0, a2}, 32'd0);
    check("restart_b1", {30'd0, b2}, 32'd1);
    repeat (15) @(negedge clk);
    check("restart_done", {31'd0, done2}, 32'd1);
    check("restart_count", cnt2, 32'd16);

    // Random WIDTH=8, seed=1, num_vec=3
    start8 = 1'b1; mode8 = 1'b1; seed8 = 32'd1; num8 = 32'd3;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rnd_a[%0d]", i), {24'd0, a8}, {24'd0, rnd_a[i]});
      check($sformatf("rnd_b[%0d]", i), {24'd0, b8}, {24'd0, rnd_b[i]});
      check($sformatf("rnd_count[%0d]", i), cnt8, i);
      check($sformatf("rnd_valid[%0d]", i), {31'd0, valid8}, 32'd1);
      @(negedge clk);
    end
    check("rnd_done",  {31'd0, done8}, 32'd1);
    check("rnd_count", cnt8, 32'd3);
    check("rnd_valid_end", {31'd0, valid8}, 32'd0);
    @(negedge clk);
    check("rnd_post_done", {31'd0, done8}, 32'd0);

    // Backpressure: 5 stalled cycles on the first vector
    ready8 = 1'b0;
    start8 = 1'b1; mode8 = 1'b1; seed8 = 32'd1; num8 = 32'd2;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_a[%0d]", k), {24'd0, a8}, 32'h01);
      check($sformatf("bp_b[%0d]", k), {24'd0, b8}, 32'h00);
      check($sformatf("bp_count[%0d]", k), cnt8, 32'd0);
      check($sformatf("bp_valid[%0d]", k), {31'd0, valid8}, 32'd1);
      if (k == 4) ready8 = 1'b1;
      @(negedge clk);
    end
    check("bp_second_a", {24'd0, a8}, 32'h03);
    check("bp_second_b", {24'd0, b8}, 32'h00);
    check("bp_second_count", cnt8, 32'd1);
    @(negedge clk);
    check("bp_done", {31'd0, done8}, 32'd1);
    check("bp_count", cnt8, 32'd2);
    @(negedge clk);

    // num_vec=0 in random mode; start raised with the done pulse is dropped
    start8 = 1'b1; mode8 = 1'b1; seed8 = 32'd5; num8 = 32'd0;
    @(negedge clk);
    start8 = 1'b0;
    check("zero_valid", {31'd0, valid8}, 32'd0);
    check("zero_done",  {31'd0, done8}, 32'd1);
    check("zero_busy",  {31'd0, busy8}, 32'd1);
    check("zero_count", cnt8, 32'd0);
    start8 = 1'b1; num8 = 32'd4;
    @(negedge clk);
    start8 = 1'b0;
    check("zero_post_busy",  {31'd0, busy8}, 32'd0);
    check("zero_post_done",  {31'd0, done8}, 32'd0);
    check("zero_post_valid", {31'd0, valid8}, 32'd0);

    // Seed 0 behaves as seed 1
    start8 = 1'b1; mode8 = 1'b1; seed8 = 32'd0; num8 = 32'd1;
    @(negedge clk);
    start8 = 1'b0;
    check("seed0_a", {24'd0, a8}, 32'h01);
    check("seed0_b", {24'd0, b8}, 32'h00);
    @(negedge clk);
    check("seed0_done",  {31'd0, done8}, 32'd1);
    check("seed0_count", cnt8, 32'd1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
